square_cfg_arbiter: RTL and testbench
=====================================

Name: square_cfg_arbiter

Overview:
- Frame-synchronous controller for the square-drawing datapath; owns the square's xpos, ypos and width registers.
- Shares them between two command requesters: requester 0 = mouse path, requester 1 = keyboard/UART path.
- Arbitrates round-robin, holds one command pending, and applies it only at frame start (hcount==0 && vcount==0) so the drawn square never tears mid-frame.
- Outputs feed the square draw stage directly.

Parameters:
- SIZE, 8: width step for GROW/SHRINK; also minimum width.
- W_MAX, 256: maximum width (saturation limit).
- X_INIT, 150: xpos after reset / RESET command.
- Y_INIT, 100: ypos after reset / RESET command.
- H_RES, 800: visible width, used for clamping.
- V_RES, 600: visible height, used for clamping.

Ports:
- clk  input  1  system clock; sole clock.
- rst  input  1  synchronous, active-high reset.
- vga_in  input  vga_if.in  timing bus; only hcount and vcount are used.
- req  input  2  per-requester request; held high until ack.
- cmd0  input  2  requester 0 command: 00 GROW, 01 SHRINK, 10 MOVE, 11 RESET.
- cmd1  input  2  requester 1 command, same encoding.
- xarg0  input  12  requester 0 MOVE x.
- yarg0  input  12  requester 0 MOVE y.
- xarg1  input  12  requester 1 MOVE x.
- yarg1  input  12  requester 1 MOVE y.
- ack  output  2  one-cycle pulse to the granted requester when its command is applied.
- busy  output  1  high in PENDING and DONE.
- xpos_square  output  12  square x.
- ypos_square  output  12  square y.
- width_square  output  12  square width (square is width x width).

Behaviour:
- Reset: state IDLE; xpos_square=X_INIT, ypos_square=Y_INIT, width_square=SIZE; ack=0; busy=0; last_grant=1 (so requester 0 wins the first tie); pending registers cleared.
- A reset mid-operation discards any pending command and issues no ack.
- frame_start = (hcount==0 && vcount==0), evaluated combinationally in the current cycle.
- IDLE:
  - If req!=0, grant one requester. Single request: grant that requester. Both requesting: grant the one not equal to last_grant.
  - Latch grant id, cmd and args; update last_grant; go to PENDING.
  - A frame_start in the latch cycle is ignored; the command waits for the next frame_start.
- PENDING:
  - Wait for frame_start. On that cycle compute the new values; registered outputs change at that clock edge.
  - At the same edge ack[grant] is asserted for exactly one cycle. Go to DONE.
- DONE:
  - One cycle. Requests are ignored here, giving the requester time to drop req after ack. Go to IDLE.
- Requester rule: cmd/args must be stable while req is high. Latching happens once, at grant, so later changes are not observed.
- Dropping req while PENDING does not cancel the command; it is still applied and acked.
- Arithmetic (12-bit unsigned):
  - GROW: width = min(width+SIZE, W_MAX).
  - SHRINK: width = (width <= 2*SIZE) ? SIZE : width-SIZE. Width never goes below SIZE.
  - MOVE: x = xarg, y = yarg; clamped per the optional feature.
  - RESET: all three outputs return to their reset values.
- Outputs change only on a frame_start edge or on rst.
- Throughput: at most one command per frame.

Optional Feature:
- Macro: SQUARE_CLAMP_EN.
- Defined:
  - MOVE clamps x to H_RES-width and y to V_RES-width when exceeded.
  - GROW that would push x+width beyond H_RES (or y+width beyond V_RES) pulls x (resp. y) back so the square stays fully visible.
- Undefined:
  - MOVE args are taken verbatim.
  - GROW never alters position; off-screen extents are allowed.

Test Plan:
1. Release rst → outputs 150/100/8, ack=0, busy=0. Pulse req=01 with cmd0=GROW mid-frame → busy=1; width stays 8 until the next frame_start; then width=16 and ack=01 for one cycle.
2. req=11, both GROW, held from IDLE → requester 0 acked at frame N (width 16), requester 1 acked at frame N+1 (width 24), then DONE→IDLE.
3. Width=8, cmd0=SHRINK → width stays 8. Width=256, GROW → width stays 256.
4. cmd1=MOVE with x=790, y=595, width=16: with SQUARE_CLAMP_EN → x=784, y=584; without → x=790, y=595.
5. Command latched, rst asserted before frame_start → no ack, outputs 150/100/8, state IDLE.
6. Requester 0 drops req after ack while requester 1 is held → DONE ignores requester 1 for one cycle; requester 1 is granted in IDLE and applied at the following frame.

Source files
------------

// File: rtl/square_cfg_arbiter.sv
// ============================================================================
// Module   : square_cfg_arbiter
// Purpose  : Round-robin arbiter owning the square's xpos/ypos/width registers;
//            commands are applied only at frame start. Optional clamping: SQUARE_CLAMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module square_cfg_arbiter #(
    parameter int SIZE   = 8,
    parameter int W_MAX  = 256,
    parameter int X_INIT = 150,
    parameter int Y_INIT = 100,
    parameter int H_RES  = 800,
    parameter int V_RES  = 600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic [1:0]  req,
    input  logic [1:0]  cmd0,
    input  logic [1:0]  cmd1,
    input  logic [11:0] xarg0,
    input  logic [11:0] yarg0,
    input  logic [11:0] xarg1,
    input  logic [11:0] yarg1,
    output logic [1:0]  ack,
    output logic        busy,
    output logic [11:0] xpos_square,
    output logic [11:0] ypos_square,
    output logic [11:0] width_square
);

    localparam logic [1:0]  c_CMD_GROW   = 2'b00;
    localparam logic [1:0]  c_CMD_SHRINK = 2'b01;
    localparam logic [1:0]  c_CMD_MOVE   = 2'b10;

    localparam logic [11:0] c_SIZE   = 12'(SIZE);
    localparam logic [11:0] c_2SIZE  = 12'(2 * SIZE);
    localparam logic [11:0] c_WMAX   = 12'(W_MAX);
    localparam logic [11:0] c_XINIT  = 12'(X_INIT);
    localparam logic [11:0] c_YINIT  = 12'(Y_INIT);
`ifdef SQUARE_CLAMP_EN
    localparam logic [11:0] c_HRES   = 12'(H_RES);
    localparam logic [11:0] c_VRES   = 12'(V_RES);
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    // A square wider than the screen could never be kept fully visible.
    if (H_RES < W_MAX || V_RES < W_MAX || SIZE < 1) begin : g_param_check
        $error("square_cfg_arbiter: W_MAX must fit within H_RES/V_RES and SIZE must be positive");
    end

    state_t      state_q;
    logic        grant_q;
    logic        last_grant_q;
    logic [1:0]  cmd_q;
    logic [11:0] xarg_q;
    logic [11:0] yarg_q;
    logic [11:0] xpos_q;
    logic [11:0] ypos_q;
    logic [11:0] width_q;
    logic [1:0]  ack_q;
    logic        busy_q;

    logic        frame_start;
    logic        grant_sel;
    logic [11:0] x_d;
    logic [11:0] y_d;
    logic [11:0] w_d;

    assign frame_start = (hcount == 11'd0) && (vcount == 11'd0);

    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign grant_sel = (req == 2'b10) || ((req == 2'b11) && !last_grant_q);

    always_comb begin
        x_d = xpos_q;
        y_d = ypos_q;
        w_d = width_q;
        case (cmd_q)
            c_CMD_GROW: begin
                w_d = (width_q >= c_WMAX - c_SIZE) ? c_WMAX : width_q + c_SIZE;
`ifdef SQUARE_CLAMP_EN
                if (({1'b0, xpos_q} + {1'b0, w_d}) > {1'b0, c_HRES}) x_d = c_HRES - w_d;
                if (({1'b0, ypos_q} + {1'b0, w_d}) > {1'b0, c_VRES}) y_d = c_VRES - w_d;
`endif
            end
            c_CMD_SHRINK: begin
                w_d = (width_q <= c_2SIZE) ? c_SIZE : width_q - c_SIZE;
            end
            c_CMD_MOVE: begin
                x_d = xarg_q;
                y_d = yarg_q;
`ifdef SQUARE_CLAMP_EN
                if (xarg_q > c_HRES - width_q) x_d = c_HRES - width_q;
                if (yarg_q > c_VRES - width_q) y_d = c_VRES - width_q;
`endif
            end
            default: begin
                x_d = c_XINIT;
                y_d = c_YINIT;
                w_d = c_SIZE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cmd_q        <= 2'b00;
            xarg_q       <= 12'd0;
            yarg_q       <= 12'd0;
            xpos_q       <= c_XINIT;
            ypos_q       <= c_YINIT;
            width_q      <= c_SIZE;
            ack_q        <= 2'b00;
            busy_q       <= 1'b0;
        end else begin
            ack_q <= 2'b00;
            case (state_q)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        grant_q      <= grant_sel;
                        last_grant_q <= grant_sel;
                        cmd_q        <= grant_sel ? cmd1  : cmd0;
                        xarg_q       <= grant_sel ? xarg1 : xarg0;
                        yarg_q       <= grant_sel ? yarg1 : yarg0;
                        busy_q       <= 1'b1;
                        state_q      <= S_PENDING;
                    end
                end
                S_PENDING: begin
                    if (frame_start) begin
                        xpos_q  <= x_d;
                        ypos_q  <= y_d;
                        width_q <= w_d;
                        ack_q   <= grant_q ? 2'b10 : 2'b01;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack          = ack_q;
    assign busy         = busy_q;
    assign xpos_square  = xpos_q;
    assign ypos_square  = ypos_q;
    assign width_square = width_q;

endmodule

`default_nettype wire

// File: tb/tb_square_cfg_arbiter.sv
// ============================================================================
// Module   : tb_square_cfg_arbiter
// Purpose  : Self-checking bench for square_cfg_arbiter (vector table, directed
//            corner sequences, randomized traffic against a behavioural model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_square_cfg_arbiter;

    localparam int SIZE   = 8;
    localparam int W_MAX  = 256;
    localparam int X_INIT = 150;
    localparam int Y_INIT = 100;
    localparam int H_RES  = 800;
    localparam int V_RES  = 600;
`ifdef SQUARE_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    localparam int GROW = 0, SHRINK = 1, MOVE = 2, RST_CMD = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic [1:0]  req;
    logic [1:0]  cmd0, cmd1;
    logic [11:0] xarg0, yarg0, xarg1, yarg1;
    logic [1:0]  ack;
    logic        busy;
    logic [11:0] xpos_square, ypos_square, width_square;

    square_cfg_arbiter #(
        .SIZE(SIZE), .W_MAX(W_MAX), .X_INIT(X_INIT), .Y_INIT(Y_INIT),
        .H_RES(H_RES), .V_RES(V_RES)
    ) dut (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
        .req(req), .cmd0(cmd0), .cmd1(cmd1),
        .xarg0(xarg0), .yarg0(yarg0), .xarg1(xarg1), .yarg1(yarg1),
        .ack(ack), .busy(busy),
        .xpos_square(xpos_square), .ypos_square(ypos_square), .width_square(width_square)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model of the square and arbitration history.
    int m_x, m_y, m_w, m_last;

    typedef struct {
        int cmd; int xa; int ya;
        int ew;  int ex; int ey;   // expected without clamping
        int exc; int eyc;          // expected with clamping
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        hcount = 11'd0;
        vcount = 11'd0;
        tick();
        hcount = 11'd7;
        vcount = 11'd3;
    endtask

    task automatic chk_outs(input string name, input int ex, input int ey, input int ew);
        chk({name, ".x"}, int'(xpos_square), ex);
        chk({name, ".y"}, int'(ypos_square), ey);
        chk({name, ".w"}, int'(width_square), ew);
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_apply(input int cmd, input int xa, input int ya);
        case (cmd)
            GROW: begin
                m_w = imin(m_w + SIZE, W_MAX);
                if (CLAMP) begin
                    m_x = imin(m_x, H_RES - m_w);
                    m_y = imin(m_y, V_RES - m_w);
                end
            end
            SHRINK: m_w = (m_w <= 2 * SIZE) ? SIZE : m_w - SIZE;
            MOVE: begin
                m_x = CLAMP ? imin(xa, H_RES - m_w) : xa;
                m_y = CLAMP ? imin(ya, V_RES - m_w) : ya;
            end
            default: begin
                m_x = X_INIT; m_y = Y_INIT; m_w = SIZE;
            end
        endcase
    endtask

    task automatic do_reset();
        req = 2'b00;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_x = X_INIT; m_y = Y_INIT; m_w = SIZE; m_last = 1;
    endtask

    task automatic set_cmd(input int r, input int cmd, input int xa, input int ya);
        if (r == 0) begin
            cmd0 = 2'(cmd); xarg0 = 12'(xa); yarg0 = 12'(ya);
        end else begin
            cmd1 = 2'(cmd); xarg1 = 12'(xa); yarg1 = 12'(ya);
        end
    endtask

    // Single-requester transaction; outputs remain valid afterwards until the next frame.
    task automatic do_txn(input string name, input int r, input int cmd, input int xa, input int ya);
        set_cmd(r, cmd, xa, ya);
        req = (r == 0) ? 2'b01 : 2'b10;
        tick();
        chk({name, ".busy"}, int'(busy), 1);
        tick();
        frame();
        chk({name, ".ack"}, int'(ack), (r == 0) ? 1 : 2);
        req = 2'b00;
        model_apply(cmd, xa, ya);
        m_last = r;
        tick();
        chk({name, ".ack_clr"}, int'(ack), 0);
        chk({name, ".idle"}, int'(busy), 0);
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; hcount = 11'd7; vcount = 11'd3;
        cmd0 = 2'b00; cmd1 = 2'b00; xarg0 = '0; yarg0 = '0; xarg1 = '0; yarg1 = '0;

        tbl[0] = '{GROW,    0,   0, 16, 150, 100, 150, 100};
        tbl[1] = '{GROW,    0,   0, 24, 150, 100, 150, 100};
        tbl[2] = '{SHRINK,  0,   0, 16, 150, 100, 150, 100};
        tbl[3] = '{SHRINK,  0,   0,  8, 150, 100, 150, 100};
        tbl[4] = '{SHRINK,  0,   0,  8, 150, 100, 150, 100};
        tbl[5] = '{MOVE,  790, 595,  8, 790, 595, 790, 592};
        tbl[6] = '{GROW,    0,   0, 16, 790, 595, 784, 584};
        tbl[7] = '{MOVE,   10,  20, 16,  10,  20,  10,  20};
        tbl[8] = '{RST_CMD, 0,   0,  8, 150, 100, 150, 100};

        // Reset state, then a GROW whose request coincides with a frame start.
        do_reset();
        chk_outs("reset", X_INIT, Y_INIT, SIZE);
        chk("reset.ack", int'(ack), 0);
        chk("reset.busy", int'(busy), 0);
        set_cmd(0, GROW, 0, 0);
        req = 2'b01; hcount = 11'd0; vcount = 11'd0;
        tick();
        hcount = 11'd7; vcount = 11'd3; req = 2'b00;
        chk("t1.busy", int'(busy), 1);
        chk("t1.w_latchframe", int'(width_square), 8);
        tick(); tick();
        chk("t1.w_wait", int'(width_square), 8);
        chk("t1.ack_wait", int'(ack), 0);
        frame();
        chk("t1.w", int'(width_square), 16);
        chk("t1.ack", int'(ack), 1);
        tick();
        chk("t1.ack_clr", int'(ack), 0);
        chk("t1.busy_clr", int'(busy), 0);

        // Vector table, requester 0 only.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            do_txn($sformatf("vec%0d", i), 0, tbl[i].cmd, tbl[i].xa, tbl[i].ya);
            chk_outs($sformatf("vec%0d", i),
                     CLAMP ? tbl[i].exc : tbl[i].ex,
                     CLAMP ? tbl[i].eyc : tbl[i].ey, tbl[i].ew);
        end

        // Both requesting after reset: requester 0 first, then 1; req0 drops after ack.
        do_reset();
        set_cmd(0, GROW, 0, 0);
        set_cmd(1, GROW, 0, 0);
        req = 2'b11;
        tick(); tick();
        frame();
        chk("rr.ack0", int'(ack), 1);
        chk("rr.w0", int'(width_square), 16);
        req = 2'b10;
        tick();
        chk("rr.done_ignores", int'(busy), 0);
        tick();
        chk("rr.grant1", int'(busy), 1);
        frame();
        chk("rr.ack1", int'(ack), 2);
        chk("rr.w1", int'(width_square), 24);
        req = 2'b00;
        tick();
        chk("rr.idle", int'(busy), 0);

        // Saturate at W_MAX.
        do_reset();
        for (int i = 0; i < 31; i++) do_txn("sat", 0, GROW, 0, 0);
        chk("sat.w256", int'(width_square), W_MAX);
        do_txn("sat_more", 0, GROW, 0, 0);
        chk_outs("sat_more", m_x, m_y, W_MAX);

        // MOVE near the corner with width 16 via requester 1.
        do_reset();
        do_txn("mv_grow", 0, GROW, 0, 0);
        do_txn("mv", 1, MOVE, 790, 595);
        chk("mv.x", int'(xpos_square), CLAMP ? 784 : 790);
        chk("mv.y", int'(ypos_square), CLAMP ? 584 : 595);

        // Reset while a command is pending discards it.
        do_reset();
        set_cmd(0, GROW, 0, 0);
        req = 2'b01;
        tick();
        req = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_outs("rstpend", X_INIT, Y_INIT, SIZE);
        chk("rstpend.busy", int'(busy), 0);
        frame();
        chk("rstpend.noack", int'(ack), 0);
        chk("rstpend.w", int'(width_square), SIZE);
        tick();
        chk("rstpend.idle", int'(busy), 0);

        // Randomized traffic against the model.
        do_reset();
        for (int it = 0; it < 80; it++) begin
            int mask, c[2], xa[2], ya[2];
            mask = int'($urandom_range(1, 3));
            for (int r = 0; r < 2; r++) begin
                c[r]  = int'($urandom_range(0, 3));
                xa[r] = int'($urandom_range(0, 1000));
                ya[r] = int'($urandom_range(0, 1000));
                set_cmd(r, c[r], xa[r], ya[r]);
            end
            if ($urandom_range(0, 3) == 0) begin
                frame();
                chk("rnd.idle_frame_ack", int'(ack), 0);
                chk_outs("rnd.idle_frame", m_x, m_y, m_w);
            end
            req = 2'(mask);
            while (mask != 0) begin
                int win, gap;
                win = (mask == 3) ? ((m_last == 1) ? 0 : 1) : ((mask == 2) ? 1 : 0);
                tick();
                chk("rnd.busy", int'(busy), 1);
                // Post-grant changes to the winner's inputs must not be observed.
                set_cmd(win, int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)),
                        int'($urandom_range(0, 4095)));
                if (mask != 3 && $urandom_range(0, 1) == 1) req = 2'b00;
                gap = int'($urandom_range(0, 3));
                for (int g = 0; g < gap; g++) tick();
                chk("rnd.hold", int'(width_square), m_w);
                frame();
                chk("rnd.ack", int'(ack), 1 << win);
                model_apply(c[win], xa[win], ya[win]);
                m_last = win;
                chk_outs("rnd", m_x, m_y, m_w);
                mask = mask & ~(1 << win);
                req = 2'(mask);
                tick();
                chk("rnd.ack_clr", int'(ack), 0);
            end
            chk("rnd.end_idle", int'(busy), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
